// File: rtl/minibyte_io_pkg.sv
// Minibyte I/O peripheral package: register offsets, reset values,
// control/status bit positions and the serial TX state encoding.
package minibyte_io_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 7;
  localparam int unsigned OFS_W  = 3;
  localparam int unsigned PS_W   = 7;
  localparam int unsigned CTL_W  = 5;

  // Register offsets within the 8-register window
  localparam logic [OFS_W-1:0] REG_GPIO_OUT = 3'd0;
  localparam logic [OFS_W-1:0] REG_GPIO_IN  = 3'd1;
  localparam logic [OFS_W-1:0] REG_TMR_CNT  = 3'd2;
  localparam logic [OFS_W-1:0] REG_TMR_RLD  = 3'd3;
  localparam logic [OFS_W-1:0] REG_TMR_CTL  = 3'd4;
  localparam logic [OFS_W-1:0] REG_STATUS   = 3'd5;
  localparam logic [OFS_W-1:0] REG_TX_DATA  = 3'd6;
  localparam logic [OFS_W-1:0] REG_TX_DIV   = 3'd7;

  // Reset values (TX_DIV comes from the top-level parameter)
  localparam logic [DATA_W-1:0] GPIO_OUT_RST = 8'h00;
  localparam logic [DATA_W-1:0] TMR_CNT_RST  = 8'h00;
  localparam logic [DATA_W-1:0] TMR_RLD_RST  = 8'hFF;
  localparam logic [DATA_W-1:0] TX_DATA_RST  = 8'h00;
  localparam logic [CTL_W-1:0]  TMR_CTL_RST  = 5'h00;

  // TMR_CTL bit positions
  localparam int unsigned CTL_EN_BIT = 0;
  localparam int unsigned CTL_PS_LSB = 1;
  localparam int unsigned CTL_IE_BIT = 4;

  // STATUS bit positions
  localparam int unsigned STAT_OVF_BIT  = 0;
  localparam int unsigned STAT_BUSY_BIT = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // Low 'ps' bits set: prescaler tick fires when these are all ones
  function automatic logic [PS_W-1:0] ps_mask(input logic [2:0] ps);
    return PS_W'((8'd1 << ps) - 8'd1);
  endfunction

endpackage

// File: rtl/minibyte_uart_tx.sv
// 8N1 serial transmitter for the Minibyte I/O peripheral.
// Ports:
//   clk_in, rst_in (sync, active-high), ena_in (global hold)
//   start   : accept a frame (only honoured while idle)
//   data    : frame byte, must stay stable while busy
//   div     : bit period minus one, sampled at each bit start
//   busy    : frame in progress (state != IDLE)
//   tx      : registered serial line, idle high
module minibyte_uart_tx
  import minibyte_io_pkg::*;
(
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              ena_in,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  input  logic [DATA_W-1:0] div,
  output logic              busy,
  output logic              tx
);

  tx_state_t         state, state_nxt;
  logic [DATA_W-1:0] baud_cnt, baud_nxt;
  logic [2:0]        bit_idx, bit_nxt;
  logic              tx_nxt;
  logic              baud_done;

  assign baud_done = (baud_cnt == '0);
  assign busy      = (state != IDLE);

  // State, counters and line register
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      tx       <= 1'b1;
    end else if (ena_in) begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_idx  <= bit_nxt;
      tx       <= tx_nxt;
    end
  end

  // Next-state: baud counter reloads from div at every bit boundary
  always_comb begin
    state_nxt = state;
    baud_nxt  = baud_cnt;
    bit_nxt   = bit_idx;
    tx_nxt    = tx;
    case (state)
      IDLE: begin
        tx_nxt = 1'b1;
        if (start) begin
          state_nxt = START;
          baud_nxt  = div;
          tx_nxt    = 1'b0;
        end
      end
      START: begin
        if (baud_done) begin
          state_nxt = DATA;
          baud_nxt  = div;
          bit_nxt   = 3'd0;
          tx_nxt    = data[0];
        end else begin
          baud_nxt = DATA_W'(baud_cnt - 8'd1);
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_nxt = div;
          if (bit_idx == 3'd7) begin
            state_nxt = STOP;
            tx_nxt    = 1'b1;
          end else begin
            bit_nxt = 3'(bit_idx + 3'd1);
            tx_nxt  = data[3'(bit_idx + 3'd1)];
          end
        end else begin
          baud_nxt = DATA_W'(baud_cnt - 8'd1);
        end
      end
      STOP: begin
        if (baud_done) begin
          state_nxt = IDLE;
          tx_nxt    = 1'b1;
        end else begin
          baud_nxt = DATA_W'(baud_cnt - 8'd1);
        end
      end
      default: begin
        state_nxt = IDLE;
        tx_nxt    = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/minibyte_io_ctrl.sv
// Minibyte memory-mapped I/O peripheral: 8-register window with GPIO out,
// synchronised GPIO in, reloadable 8-bit timer with IRQ, and 8N1 TX.
// Ports:
//   clk_in, rst_in (sync, active-high), ena_in (global hold)
//   addr_in/data_in/we_in : CPU bus
//   data_out, hit_out     : combinational read data / window decode
//   gpio_out, gpio_in     : GPIO latch out, asynchronous inputs
//   tx_out                : serial line, idle high
//   irq_out               : timer overflow interrupt (ovf & ie)
module minibyte_io_ctrl
  import minibyte_io_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 7'h78,
  parameter logic [DATA_W-1:0] TX_DIV_RST = 8'h0F
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              ena_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              we_in,
  output logic [DATA_W-1:0] data_out,
  output logic              hit_out,
  output logic [DATA_W-1:0] gpio_out,
  input  logic [DATA_W-1:0] gpio_in,
  output logic              tx_out,
  output logic              irq_out
);

  logic [OFS_W-1:0]  offset;
  logic              wr;
  logic [DATA_W-1:0] gpio_meta, gpio_sync;
  logic [DATA_W-1:0] tmr_cnt, tmr_cnt_nxt;
  logic [DATA_W-1:0] tmr_rld;
  logic [CTL_W-1:0]  tmr_ctl;
  logic [PS_W-1:0]   prescaler;
  logic [PS_W-1:0]   tick_mask;
  logic              tmr_en, tmr_ie, tick, ovf, ovf_set, ovf_nxt;
  logic [DATA_W-1:0] tx_data, tx_div;
  logic              tx_start, tx_busy;

  // Window decode and qualified write strobe
  assign offset  = addr_in[OFS_W-1:0];
  assign hit_out = (addr_in[ADDR_W-1:OFS_W] == BASE_ADDR[ADDR_W-1:OFS_W]);
  assign wr      = we_in & hit_out & ena_in;

  assign tmr_en    = tmr_ctl[CTL_EN_BIT];
  assign tmr_ie    = tmr_ctl[CTL_IE_BIT];
  assign tick_mask = ps_mask(tmr_ctl[CTL_PS_LSB +: 3]);
  assign tick      = tmr_en & ((prescaler & tick_mask) == tick_mask);
  assign ovf_set   = tick & (tmr_cnt == 8'hFF);
  assign irq_out   = ovf & tmr_ie;

  // A TX_DATA write while busy is dropped entirely
  assign tx_start = wr & (offset == REG_TX_DATA) & ~tx_busy;

  // Timer count: an RLD write overrides the tick on the same edge
  always_comb begin
    tmr_cnt_nxt = tmr_cnt;
    if (tick) begin
      tmr_cnt_nxt = ovf_set ? tmr_rld : DATA_W'(tmr_cnt + 8'd1);
    end
    if (wr && (offset == REG_TMR_RLD)) begin
      tmr_cnt_nxt = data_in;
    end
  end

  // Sticky overflow: a set on the same edge beats the W1C
  always_comb begin
    ovf_nxt = ovf;
    if (wr && (offset == REG_STATUS) && data_in[STAT_OVF_BIT]) begin
      ovf_nxt = 1'b0;
    end
    if (ovf_set) begin
      ovf_nxt = 1'b1;
    end
  end

  // Register bank, timer and GPIO synchroniser
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      gpio_out  <= GPIO_OUT_RST;
      gpio_meta <= '0;
      gpio_sync <= '0;
      tmr_cnt   <= TMR_CNT_RST;
      tmr_rld   <= TMR_RLD_RST;
      tmr_ctl   <= TMR_CTL_RST;
      prescaler <= '0;
      ovf       <= 1'b0;
      tx_data   <= TX_DATA_RST;
      tx_div    <= TX_DIV_RST;
    end else if (ena_in) begin
      gpio_meta <= gpio_in;
      gpio_sync <= gpio_meta;
      prescaler <= tmr_en ? PS_W'(prescaler + 7'd1) : '0;
      tmr_cnt   <= tmr_cnt_nxt;
      ovf       <= ovf_nxt;
      if (wr && (offset == REG_GPIO_OUT)) gpio_out <= data_in;
      if (wr && (offset == REG_TMR_RLD))  tmr_rld  <= data_in;
      if (wr && (offset == REG_TMR_CTL))  tmr_ctl  <= data_in[CTL_W-1:0];
      if (wr && (offset == REG_TX_DIV))   tx_div   <= data_in;
      if (tx_start)                       tx_data  <= data_in;
    end
  end

  // Read mux; zero outside the window
  always_comb begin
    data_out = '0;
    if (hit_out) begin
      case (offset)
        REG_GPIO_OUT: data_out = gpio_out;
        REG_GPIO_IN:  data_out = gpio_sync;
        REG_TMR_CNT:  data_out = tmr_cnt;
        REG_TMR_RLD:  data_out = tmr_rld;
        REG_TMR_CTL:  data_out = DATA_W'(tmr_ctl);
        REG_STATUS:   data_out = {6'b0, tx_busy, ovf};
        REG_TX_DATA:  data_out = tx_data;
        REG_TX_DIV:   data_out = tx_div;
        default:      data_out = '0;
      endcase
    end
  end

  minibyte_uart_tx u_uart_tx (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .ena_in (ena_in),
    .start  (tx_start),
    .data   (tx_data),
    .div    (tx_div),
    .busy   (tx_busy),
    .tx     (tx_out)
  );

endmodule

// File: tb/tb_minibyte_io_ctrl.sv
// Directed self-checking bench for minibyte_io_ctrl.
module tb_minibyte_io_ctrl;

  logic       clk;
  logic       rst;
  logic       ena;
  logic [6:0] addr;
  logic [7:0] din;
  logic       we;
  logic [7:0] dout;
  logic       hit;
  logic [7:0] gpio_o;
  logic [7:0] gpio_i;
  logic       tx;
  logic       irq;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] v;

  minibyte_io_ctrl #(
    .BASE_ADDR  (7'h78),
    .TX_DIV_RST (8'h0F)
  ) dut (
    .clk_in   (clk),
    .rst_in   (rst),
    .ena_in   (ena),
    .addr_in  (addr),
    .data_in  (din),
    .we_in    (we),
    .data_out (dout),
    .hit_out  (hit),
    .gpio_out (gpio_o),
    .gpio_in  (gpio_i),
    .tx_out   (tx),
    .irq_out  (irq)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [6:0] a, input logic [7:0] d);
    addr = a;
    din  = d;
    we   = 1'b1;
    @(posedge clk);
    #1;
    we   = 1'b0;
  endtask

  task automatic rd(input logic [6:0] a, output logic [7:0] d);
    addr = a;
    we   = 1'b0;
    #1;
    d = dout;
  endtask

  task automatic test_reset();
    logic [63:0] tbl;
    tbl = 64'h0F_00_00_00_FF_00_3C_00;
    rst = 1'b1; ena = 1'b1; we = 1'b0; addr = 7'h00; din = 8'h00;
    gpio_i = 8'h3C;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    n_checks++;
    if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b exp 1", tx); end
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b exp 0", irq); end
    n_checks++;
    if (gpio_o !== 8'h00) begin n_fail++; $display("FAIL reset_gpio_out: got %h exp 00", gpio_o); end
    rd(7'h79, v);
    n_checks++;
    if (v !== 8'h00) begin n_fail++; $display("FAIL sync_lat0: got %h exp 00", v); end
    step();
    rd(7'h79, v);
    n_checks++;
    if (v !== 8'h00) begin n_fail++; $display("FAIL sync_lat1: got %h exp 00", v); end
    step();
    for (int i = 0; i < 8; i++) begin
      rd(7'(7'h78 + i), v);
      n_checks++;
      if (v !== tbl[8*i +: 8]) begin
        n_fail++; $display("FAIL reset_reg%0d: got %h exp %h", i, v, tbl[8*i +: 8]);
      end
    end
    n_checks++;
    if (hit !== 1'b1) begin n_fail++; $display("FAIL hit_in_window: got %b exp 1", hit); end
  endtask

  task automatic test_gpio();
    wr(7'h78, 8'h5A);
    rd(7'h78, v);
    n_checks++;
    if (v !== 8'h5A) begin n_fail++; $display("FAIL gpio_rd: got %h exp 5a", v); end
    n_checks++;
    if (gpio_o !== 8'h5A) begin n_fail++; $display("FAIL gpio_out: got %h exp 5a", gpio_o); end
    addr = 7'h70; din = 8'h11; we = 1'b1;
    #1;
    n_checks++;
    if (hit !== 1'b0) begin n_fail++; $display("FAIL miss_hit: got %b exp 0", hit); end
    n_checks++;
    if (dout !== 8'h00) begin n_fail++; $display("FAIL miss_data: got %h exp 00", dout); end
    step();
    we = 1'b0;
    n_checks++;
    if (gpio_o !== 8'h5A) begin n_fail++; $display("FAIL miss_nowrite: got %h exp 5a", gpio_o); end
    wr(7'h79, 8'hFF);
    rd(7'h79, v);
    n_checks++;
    if (v !== 8'h3C) begin n_fail++; $display("FAIL gpio_in_ro: got %h exp 3c", v); end
    wr(7'h7A, 8'h77);
    rd(7'h7A, v);
    n_checks++;
    if (v !== 8'h00) begin n_fail++; $display("FAIL cnt_ro: got %h exp 00", v); end
  endtask

  task automatic test_timer();
    wr(7'h7B, 8'hFD);
    rd(7'h7A, v);
    n_checks++;
    if (v !== 8'hFD) begin n_fail++; $display("FAIL rld_loads_cnt: got %h exp fd", v); end
    wr(7'h7C, 8'h11);
    rd(7'h7C, v);
    n_checks++;
    if (v !== 8'h11) begin n_fail++; $display("FAIL ctl_rd: got %h exp 11", v); end
    rd(7'h7A, v);
    n_checks++;
    if (v !== 8'hFD) begin n_fail++; $display("FAIL cnt_seq0: got %h exp fd", v); end
    step();
    rd(7'h7A, v);
    n_checks++;
    if (v !== 8'hFE) begin n_fail++; $display("FAIL cnt_seq1: got %h exp fe", v); end
    step();
    rd(7'h7A, v);
    n_checks++;
    if (v !== 8'hFF) begin n_fail++; $display("FAIL cnt_seq2: got %h exp ff", v); end
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_early: got %b exp 0", irq); end
    step();
    rd(7'h7A, v);
    n_checks++;
    if (v !== 8'hFD) begin n_fail++; $display("FAIL cnt_reload: got %h exp fd", v); end
    rd(7'h7D, v);
    n_checks++;
    if (v !== 8'h01) begin n_fail++; $display("FAIL ovf_set: got %h exp 01", v); end
    n_checks++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_set: got %b exp 1", irq); end
    // W1C on a non-overflow edge clears
    wr(7'h7D, 8'h01);
    rd(7'h7D, v);
    n_checks++;
    if (v !== 8'h00) begin n_fail++; $display("FAIL ovf_w1c: got %h exp 00", v); end
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_clr: got %b exp 0", irq); end
    step();
    // W1C on an overflow edge: set wins
    wr(7'h7D, 8'h01);
    rd(7'h7D, v);
    n_checks++;
    if (v !== 8'h01) begin n_fail++; $display("FAIL ovf_set_wins: got %h exp 01", v); end
    rd(7'h7A, v);
    n_checks++;
    if (v !== 8'hFD) begin n_fail++; $display("FAIL cnt_reload2: got %h exp fd", v); end
    wr(7'h7D, 8'h00);
    rd(7'h7D, v);
    n_checks++;
    if (v !== 8'h01) begin n_fail++; $display("FAIL ovf_w0: got %h exp 01", v); end
    wr(7'h7C, 8'h01);
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_ie_off: got %b exp 0", irq); end
    wr(7'h7C, 8'h00);
    wr(7'h7D, 8'h01);
    rd(7'h7D, v);
    n_checks++;
    if (v !== 8'h00) begin n_fail++; $display("FAIL ovf_clr2: got %h exp 00", v); end
    // RLD write coinciding with an overflow tick
    wr(7'h7B, 8'hFF);
    wr(7'h7C, 8'h01);
    wr(7'h7B, 8'h40);
    rd(7'h7A, v);
    n_checks++;
    if (v !== 8'h40) begin n_fail++; $display("FAIL rld_wins: got %h exp 40", v); end
    rd(7'h7D, v);
    n_checks++;
    if (v !== 8'h01) begin n_fail++; $display("FAIL rld_ovf: got %h exp 01", v); end
    wr(7'h7C, 8'h00);
    wr(7'h7D, 8'h01);
  endtask

  task automatic test_prescale_enable();
    logic [7:0] e;
    wr(7'h7B, 8'h00);
    wr(7'h7C, 8'h07);
    for (int i = 1; i <= 16; i++) begin
      step();
      e = (i >= 16) ? 8'h02 : (i >= 8) ? 8'h01 : 8'h00;
      rd(7'h7A, v);
      n_checks++;
      if (v !== e) begin n_fail++; $display("FAIL ps3_clk%0d: got %h exp %h", i, v, e); end
    end
    ena = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      rd(7'h7A, v);
      n_checks++;
      if (v !== 8'h02) begin n_fail++; $display("FAIL freeze%0d: got %h exp 02", i, v); end
    end
    wr(7'h78, 8'hFF);
    n_checks++;
    if (gpio_o !== 8'h5A) begin n_fail++; $display("FAIL freeze_wr: got %h exp 5a", gpio_o); end
    ena = 1'b1;
    repeat (7) step();
    rd(7'h7A, v);
    n_checks++;
    if (v !== 8'h02) begin n_fail++; $display("FAIL resume7: got %h exp 02", v); end
    step();
    rd(7'h7A, v);
    n_checks++;
    if (v !== 8'h03) begin n_fail++; $display("FAIL resume8: got %h exp 03", v); end
    wr(7'h7C, 8'h00);
  endtask

  task automatic test_uart();
    logic [9:0]  frame;
    logic [63:0] tbl;
    frame = {1'b1, 8'hA5, 1'b0};
    tbl   = 64'h0F_00_00_00_FF_00_00_00;
    wr(7'h7F, 8'h01);
    wr(7'h7E, 8'hA5);
    for (int k = 0; k < 20; k++) begin
      n_checks++;
      if (tx !== frame[k/2]) begin
        n_fail++; $display("FAIL tx_bit_clk%0d: got %b exp %b", k, tx, frame[k/2]);
      end
      rd(7'h7D, v);
      n_checks++;
      if (v[1] !== 1'b1) begin n_fail++; $display("FAIL busy_clk%0d: got %b exp 1", k, v[1]); end
      if (k == 6) wr(7'h7E, 8'h3C);
      else        step();
    end
    rd(7'h7D, v);
    n_checks++;
    if (v !== 8'h00) begin n_fail++; $display("FAIL busy_end: got %h exp 00", v); end
    n_checks++;
    if (tx !== 1'b1) begin n_fail++; $display("FAIL tx_idle: got %b exp 1", tx); end
    rd(7'h7E, v);
    n_checks++;
    if (v !== 8'hA5) begin n_fail++; $display("FAIL busy_wr_ignored: got %h exp a5", v); end
    wr(7'h7E, 8'h3C);
    rd(7'h7E, v);
    n_checks++;
    if (v !== 8'h3C) begin n_fail++; $display("FAIL idle_wr: got %h exp 3c", v); end
    n_checks++;
    if (tx !== 1'b0) begin n_fail++; $display("FAIL start2: got %b exp 0", tx); end
    repeat (10) step();
    n_checks++;
    if (tx !== 1'b1) begin n_fail++; $display("FAIL bit4: got %b exp 1", tx); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if (tx !== 1'b1) begin n_fail++; $display("FAIL rst_tx: got %b exp 1", tx); end
    n_checks++;
    if (gpio_o !== 8'h00) begin n_fail++; $display("FAIL rst_gpio: got %h exp 00", gpio_o); end
    for (int i = 0; i < 8; i++) begin
      rd(7'(7'h78 + i), v);
      n_checks++;
      if (v !== tbl[8*i +: 8]) begin
        n_fail++; $display("FAIL midrst_reg%0d: got %h exp %h", i, v, tbl[8*i +: 8]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_gpio();
    test_timer();
    test_prescale_enable();
    test_uart();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/minibyte_io_ctrl.md
Name: minibyte_io_ctrl

Overview:
- Memory-mapped I/O peripheral on the Minibyte CPU's external bus, downstream of the CPU's 7-bit address / 8-bit data / WE outputs.
- Decodes an 8-register window and provides:
  - GPIO output latch
  - Synchronised GPIO input
  - 8-bit reloadable timer with sticky overflow and IRQ
  - 8N1 serial transmitter
- Read data plus a hit flag feed the top-level input-device mux, so the CPU can read peripheral registers in place of external memory.

Parameters:
- BASE_ADDR, 7'h78: base of 8-register window; must be 8-aligned. Decode is addr_in[6:3] == BASE_ADDR[6:3].
- TX_DIV_RST, 8'h0F: reset value of TX_DIV register.

Ports:
- clk_in  in  1  system clock; all state updates on rising edge
- rst_in  in  1  synchronous reset, active-high
- ena_in  in  1  global enable; when low all state holds (tx_out and gpio_out hold current value)
- addr_in  in  7  CPU address bus
- data_in  in  8  CPU write data
- we_in  in  1  CPU write enable
- data_out  out  8  read data; combinational; 8'h00 when not hit
- hit_out  out  1  addr_in within window; combinational
- gpio_out  out  8  GPIO_OUT register
- gpio_in  in  8  asynchronous GPIO inputs
- tx_out  out  1  serial line, idle high
- irq_out  out  1  STATUS.ovf & TMR_CTL.ie

Behaviour:
- Reset values:
  - GPIO_OUT = 0; TMR_CNT = 0; TMR_RLD = FF; TMR_CTL = 0; ovf = 0; TX_DATA = 0; TX_DIV = TX_DIV_RST.
  - Prescaler = 0; sync flops = 0; tx FSM IDLE; tx_out = 1; irq_out = 0.
- Write: occurs at the clock edge where we_in & hit_out & ena_in. Effect is visible on a read the next cycle.
- Register map (offset = addr_in[2:0]):
  - 0 GPIO_OUT, rw.
  - 1 GPIO_IN, ro. Two-flop synchroniser, so 2-cycle latency from gpio_in. Writes ignored.
  - 2 TMR_CNT, ro.
  - 3 TMR_RLD, rw. A write also loads TMR_CNT with the written value on the same edge.
  - 4 TMR_CTL, rw:
    - bit0 en; bits[3:1] ps; bit4 ie.
    - bits[7:5] read 0, writes ignored.
  - 5 STATUS:
    - bit0 ovf, W1C; bit1 tx_busy, ro; others read 0.
    - Writing 0 to bit0 has no effect.
  - 6 TX_DATA, rw. A write while IDLE latches the data and starts a frame. A write while busy is ignored entirely: register and frame unchanged.
  - 7 TX_DIV, rw. Bit period = TX_DIV+1 clocks, sampled when each bit starts.
- Timer:
  - 7-bit free-running prescaler counts while en=1; it is cleared while en=0.
  - tick = en & (prescaler[ps-1:0] all ones); ps=0 means tick every clock. Max divide 128.
  - On tick: if TMR_CNT == FF, then TMR_CNT <= TMR_RLD and ovf <= 1; else TMR_CNT+1 (8-bit wrap).
  - Same-edge TMR_RLD write and tick: the write wins for TMR_CNT; ovf is still set if the overflow condition held.
  - Same-edge ovf set and W1C: set wins (ovf stays 1).
- Serial TX FSM:
  - States IDLE → START → DATA → STOP → IDLE.
  - START drives 0; DATA drives TX_DATA LSB-first, 8 bits; STOP drives 1. Each state lasts TX_DIV+1 clocks.
  - tx_busy = (state != IDLE).
  - First start-bit cycle is the clock after the write edge.
  - A new write is accepted in the cycle after STOP completes, not during STOP.
- Reset mid-frame: FSM returns to IDLE and tx_out goes to 1 on the reset edge.
- Reset mid-count: timer and prescaler are cleared.
- Non-hit addresses: no state change; data_out = 0.

Decomposition:
- Package minibyte_io_pkg contains:
  - Register offset constants REG_GPIO_OUT..REG_TX_DIV.
  - Reset-value constants.
  - TMR_CTL / STATUS bit-index constants.
  - tx_state_t enum: IDLE, START, DATA, STOP.
- Sub-module minibyte_uart_tx: baud counter, bit counter and FSM.
  - Ports: clk_in, rst_in, ena_in, start, data[7:0], div[7:0], busy, tx.
- Top: decode, registers, timer, read mux.

Test Plan:
- Reset, then read offsets 0–7 at BASE 78h → 00, sync'd gpio_in, 00, FF, 00, 00, 00, 0F. tx_out=1, irq_out=0.
- Write 5Ah to 78h, then read 78h → 5Ah and gpio_out=5Ah. Write to 70h → gpio_out unchanged, hit_out=0, data_out=00.
- Write RLD=FD, then CTL=11h (en, ps=0, ie) → CNT sequence FD, FE, FF, FD. ovf and irq_out assert on the FF→FD edge. Write 01h to 7Dh → ovf=0. Assert W1C on an overflow edge → ovf stays 1.
- CTL=07h (ps=3) → CNT increments once every 8 clocks.
- TX_DIV=01, write A5h to 7Eh → tx_out per 2-clock bit: 0, 1,0,1,0,0,1,0,1, 1. STATUS bit1=1 for 20 clocks. Write 3Ch mid-frame → ignored; read 7Eh → A5h.
- Assert rst_in during DATA bit 4 → next cycle tx_out=1, busy=0, all registers at reset values. ena_in=0 for 5 clocks with timer running → CNT frozen.
